network_top: RTL and testbench
==============================

# network_top

Fixed-point two-layer perceptron accelerator with an AXI4-Lite slave register file, sitting at the top of the inference datapath. Host software loads hidden/output weights and biases plus a 5x5 input grid, then pulses start. A single time-multiplexed MAC evaluates the hidden layer, then the output layer. Results and status are read back over AXI4-Lite.

## Interface
- NUM_INPUTS, 25, input grid cells (5x5)
- NUM_HL_NODES, 8, hidden-layer neurons
- NUM_OL_NODES, 5, output-layer neurons
- DATA_W, 24, signed fixed-point width
- FRAC_BITS, 21, fraction bits (Q3.21; 0x200000 = +1.0, 0xE00000 = -1.0)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-high
- axi4l_port  axi4l_if slave modport  ADDR 32 / DATA 32  AW/W/B/AR/R channels (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready)

## Operation
- Register map (byte offsets, 4-byte stride; values in bits [23:0], bits [31:24] write-ignored, read 0):
  - CORE_CTRL 0x000: bit1 start (self-clearing, reads 0); bit0 clear (zeroes OUTPUT and done)
  - CORE_STATUS 0x004 (RO): bit0 busy, bit1 done
  - INPUT_GRID_i 0x100 + 4i, i < NUM_INPUTS
  - HL_BIAS_o 0x800 + 4o; OL_BIAS_o 0xA00 + 4o
  - OUTPUT_o 0xC00 + 4o (RO)
  - HL_WEIGHTS_o_i 0x1000 + 4(o*NUM_INPUTS + i)
  - OL_WEIGHTS_o_h 0x2000 + 4(o*NUM_HL_NODES + h)
- Unmapped address: write dropped, read returns 0; all responses OKAY (2'b00). wstrb ignored (full-word writes).
- Writes to any config/input register while busy are dropped (OKAY response). start while busy ignored.
- FSM: IDLE -> HL_BIAS -> HL_MAC (NUM_INPUTS cycles) -> HL_ACT -> next hidden node or OL_BIAS -> OL_MAC (NUM_HL_NODES cycles) -> OL_ACT -> next output node or DONE -> IDLE.
- Arithmetic: acc initialised to bias << FRAC_BITS (56-bit signed); each MAC adds full 48-bit product x*w; at ACT, acc >>> FRAC_BITS (floor), then hard-tanh clamp to [0xE00000, 0x200000].
- Hidden results stored in internal array (not host-visible); output results written to OUTPUT_o.
- DONE: sets done=1, busy=0; done cleared by next start or clear.

## Timing
- Reset: all registers, weights, biases, inputs, OUTPUT = 0; FSM IDLE; busy=done=0; awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
- Write: accepted when awvalid and wvalid both high; awready/wready pulse together 1 cycle; register updated that edge; bvalid next cycle, held until bready. One outstanding write.
- Read: arready pulses 1 cycle on arvalid; rvalid+rdata next cycle, held until rready. One outstanding read; reads have priority only over nothing (independent channels).
- Compute: start write edge -> busy=1 next cycle. Per hidden node NUM_INPUTS+2 cycles, per output node NUM_HL_NODES+2 cycles; done=1 at cycle NH*(NI+2)+NO*(NH+2)+1 after start (267 at defaults).
- Reset mid-compute aborts immediately to IDLE with all state cleared.

## Test plan
- Reset then read CORE_STATUS, OUTPUT_0, HL_WEIGHTS_0_0 -> all 0x00000000; read 0x3FFC (unmapped) -> 0, OKAY.
- All weights 0, OL_BIAS_o = 0x100000, start (CTRL=0x2) -> done after 267 cycles, every OUTPUT_o = 0x00100000.
- HL_WEIGHTS_0_0 = 0x200000, INPUT_GRID_0 = 0xE00000, OL_WEIGHTS_0_0 = 0x100000, others 0 -> OUTPUT_0 = 0x00F00000 (-0.5).
- All HL weights 0x200000, inputs 0x200000, OL_WEIGHTS_o_h = 0x200000 -> hidden saturates to +1.0, OUTPUT_o = 0x00200000 (clamped from 8.0).
- Write INPUT_GRID_0 while busy, re-read after done -> old value retained; status busy=1 sampled mid-run, done=1 after.
- Assert rstn mid-compute -> busy=done=0, OUTPUT_0 = 0, subsequent start completes normally.

Source files
------------

// File: rtl/network_top.sv
// network_top: two-layer Q3.21 perceptron accelerator with an AXI4-Lite register file.
// One time-multiplexed MAC walks the hidden layer, then the output layer.
module network_top #(
  parameter int NUM_INPUTS   = 25,
  parameter int NUM_HL_NODES = 8,
  parameter int NUM_OL_NODES = 5,
  parameter int DATA_W       = 24,
  parameter int FRAC_BITS    = 21
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);
  localparam int NI  = NUM_INPUTS;
  localparam int NH  = NUM_HL_NODES;
  localparam int NO  = NUM_OL_NODES;
  localparam int DW  = DATA_W;
  localparam int AW  = 2 * DW + 8;
  localparam int II  = $clog2(NI);
  localparam int HI  = $clog2(NH);
  localparam int OI  = $clog2(NO);
  localparam int HWI = $clog2(NH * NI);
  localparam int OWI = $clog2(NO * NH);
  localparam int NW  = $clog2(NH > NO ? NH : NO);
  localparam int CW  = $clog2(NI > NH ? NI : NH);
  localparam logic signed [AW-1:0] ONE = AW'(1) <<< FRAC_BITS;
  localparam logic signed [AW-1:0] NEG = -ONE;

  typedef enum logic [2:0] {IDLE, HL_BIAS, HL_MAC, HL_ACT, OL_BIAS, OL_MAC, OL_ACT, DONE} state_t;
  typedef enum logic [3:0] {R_NONE, R_CTRL, R_STAT, R_IN, R_HB, R_OB, R_OUT, R_HW, R_OW} reg_t;

  state_t st;
  logic busy, done;
  logic [NW-1:0] node;
  logic [CW-1:0] cnt;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] in_mem [NI];
  logic signed [DW-1:0] hb [NH];
  logic signed [DW-1:0] ob [NO];
  logic signed [DW-1:0] out_mem [NO];
  logic signed [DW-1:0] hw [NH*NI];
  logic signed [DW-1:0] ow [NO*NH];
  logic signed [DW-1:0] hid [NH];
  logic [31:0] ar_addr, w_idx, r_idx, rd_val;
  reg_t wr_reg, rd_reg;
  logic wr_go, ar_go;
  logic signed [DW-1:0] mac_x, mac_w;
  logic signed [2*DW-1:0] prod;
  logic unused_bits;

  function automatic logic hit(input logic [31:0] a, input logic [31:0] b, input int n);
    return a >= b && a < b + 32'(4 * n);
  endfunction

  function automatic reg_t dec(input logic [31:0] a);
    return a[31:2] == 30'd0 ? R_CTRL : a[31:2] == 30'd1 ? R_STAT :
           hit(a, 32'h100, NI) ? R_IN : hit(a, 32'h800, NH) ? R_HB :
           hit(a, 32'hA00, NO) ? R_OB : hit(a, 32'hC00, NO) ? R_OUT :
           hit(a, 32'h1000, NH * NI) ? R_HW : hit(a, 32'h2000, NO * NH) ? R_OW : R_NONE;
  endfunction

  function automatic logic [31:0] offs(input logic [31:0] a, input reg_t r);
    return (a - (r == R_IN ? 32'h100 : r == R_HB ? 32'h800 : r == R_OB ? 32'hA00 :
                 r == R_OUT ? 32'hC00 : r == R_HW ? 32'h1000 : 32'h2000)) >> 2;
  endfunction

  function automatic logic [31:0] zx(input logic signed [DW-1:0] x);
    return {{(32-DW){1'b0}}, x};
  endfunction

  function automatic logic signed [AW-1:0] ext(input logic signed [DW-1:0] x);
    return {{(AW-DW){x[DW-1]}}, x};
  endfunction

  // Floor back to Q3.21, then hard-tanh clamp to [-1.0, +1.0]
  function automatic logic signed [DW-1:0] act(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> FRAC_BITS;
    return s > ONE ? ONE[DW-1:0] : s < NEG ? NEG[DW-1:0] : s[DW-1:0];
  endfunction

  assign bresp = 2'b00;
  assign rresp = 2'b00;

  always_comb begin
    wr_go = awvalid && wvalid && !awready && !bvalid;
    ar_go = arvalid && !arready && !rvalid;
    wr_reg = dec(awaddr);
    rd_reg = dec(ar_addr);
    w_idx = offs(awaddr, wr_reg);
    r_idx = offs(ar_addr, rd_reg);
    rd_val = rd_reg == R_STAT ? {30'd0, done, busy} :
             rd_reg == R_IN   ? zx(in_mem[II'(r_idx)]) :
             rd_reg == R_HB   ? zx(hb[HI'(r_idx)]) :
             rd_reg == R_OB   ? zx(ob[OI'(r_idx)]) :
             rd_reg == R_OUT  ? zx(out_mem[OI'(r_idx)]) :
             rd_reg == R_HW   ? zx(hw[HWI'(r_idx)]) :
             rd_reg == R_OW   ? zx(ow[OWI'(r_idx)]) : 32'd0;
    mac_x = st == HL_MAC ? in_mem[II'(cnt)] : hid[HI'(cnt)];
    mac_w = st == HL_MAC ? hw[HWI'(node * NI + cnt)] : ow[OWI'(node * NH + cnt)];
    prod = 48'(mac_x) * 48'(mac_w);
    unused_bits = ^{wstrb, wdata[31:DW]};
  end

  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      node <= '0;
      cnt <= '0;
      acc <= '0;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      ar_addr <= '0;
      for (int i = 0; i < NI; i++) in_mem[i] <= '0;
      for (int i = 0; i < NH; i++) begin
        hb[i] <= '0;
        hid[i] <= '0;
      end
      for (int i = 0; i < NO; i++) begin
        ob[i] <= '0;
        out_mem[i] <= '0;
      end
      for (int i = 0; i < NH * NI; i++) hw[i] <= '0;
      for (int i = 0; i < NO * NH; i++) ow[i] <= '0;
    end else begin
      awready <= wr_go;
      wready <= wr_go;
      bvalid <= awready || (bvalid && !bready);
      arready <= ar_go;
      if (ar_go) ar_addr <= araddr;
      rvalid <= arready || (rvalid && !rready);
      if (arready) rdata <= rd_val;
      // Host writes land only while idle; the FSM owns the arrays during a run
      if (wr_go && !busy) begin
        if (wr_reg == R_CTRL && wdata[0]) begin
          done <= 1'b0;
          for (int i = 0; i < NO; i++) out_mem[i] <= '0;
        end
        if (wr_reg == R_CTRL && wdata[1]) begin
          st <= HL_BIAS;
          busy <= 1'b1;
          done <= 1'b0;
          node <= '0;
        end
        if (wr_reg == R_IN) in_mem[II'(w_idx)] <= wdata[DW-1:0];
        if (wr_reg == R_HB) hb[HI'(w_idx)] <= wdata[DW-1:0];
        if (wr_reg == R_OB) ob[OI'(w_idx)] <= wdata[DW-1:0];
        if (wr_reg == R_HW) hw[HWI'(w_idx)] <= wdata[DW-1:0];
        if (wr_reg == R_OW) ow[OWI'(w_idx)] <= wdata[DW-1:0];
      end
      case (st)
        HL_BIAS: begin
          acc <= ext(hb[HI'(node)]) <<< FRAC_BITS;
          cnt <= '0;
          st <= HL_MAC;
        end
        HL_MAC: begin
          acc <= acc + AW'(prod);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NI - 1)) st <= HL_ACT;
        end
        HL_ACT: begin
          hid[HI'(node)] <= act(acc);
          node <= node == NW'(NH - 1) ? NW'(0) : node + 1'b1;
          st <= node == NW'(NH - 1) ? OL_BIAS : HL_BIAS;
        end
        OL_BIAS: begin
          acc <= ext(ob[OI'(node)]) <<< FRAC_BITS;
          cnt <= '0;
          st <= OL_MAC;
        end
        OL_MAC: begin
          acc <= acc + AW'(prod);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NH - 1)) st <= OL_ACT;
        end
        OL_ACT: begin
          out_mem[OI'(node)] <= act(acc);
          node <= node + 1'b1;
          st <= node == NW'(NO - 1) ? DONE : OL_BIAS;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_network_top.sv
// tb_network_top: directed scoreboard bench for network_top; reads queue expectations,
// a negedge monitor pops and compares on every R handshake.
module tb_network_top;
  logic clk = 1'b0, rstn = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0] wstrb = 4'hF;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int errors = 0, checks = 0, cyc = 0, wr_cyc = 0, c0;

  typedef struct {logic chk; logic [31:0] exp; string nm;} exp_t;
  typedef struct {logic [31:0] got; logic [31:0] lo; logic [31:0] hi; string nm;} dchk_t;
  exp_t q[$];
  dchk_t dq[$];
  exp_t e;
  dchk_t dx;

  network_top dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_read got=%h expected=none", rdata);
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          if (rdata !== e.exp || rresp !== 2'b00) begin
            errors++;
            $display("FAIL %s got=%h resp=%0d expected=%h resp=0", e.nm, rdata, rresp, e.exp);
          end
        end
      end
    end
    while (dq.size() > 0) begin
      dx = dq.pop_front();
      checks++;
      if (dx.got < dx.lo || dx.got > dx.hi) begin
        errors++;
        $display("FAIL %s got=%0d expected=%0d..%0d", dx.nm, dx.got, dx.lo, dx.hi);
      end
    end
  end

  task automatic dchk(input logic [31:0] got, input logic [31:0] lo, input logic [31:0] hi, input string nm);
    dq.push_back('{got, lo, hi, nm});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk);
    #1 awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1 n++; end
    wr_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    if (n >= 50) dchk(0, 1, 1, "aw_timeout");
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1 n++; end
    if (n >= 50) dchk(0, 1, 1, "b_timeout");
  endtask

  task automatic rd(input logic [31:0] a, input logic chk, input logic [31:0] exp,
                    input string nm, output logic [31:0] d);
    int n;
    q.push_back('{chk, exp, nm});
    @(posedge clk);
    #1 araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1 n++; end
    arvalid = 1'b0;
    if (n >= 50) dchk(0, 1, 1, {nm, "_ar_timeout"});
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1 n++; end
    if (n >= 50) dchk(0, 1, 1, {nm, "_r_timeout"});
    d = rdata;
  endtask

  task automatic rc(input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    rd(a, 1'b1, exp, nm, d);
  endtask

  // Done is first visible on a status poll 268..270 cycles after the start edge
  task automatic wait_done(input string nm, input int s);
    logic [31:0] d;
    int n;
    d = '0;
    n = 0;
    while (!d[1] && n < 200) begin
      rd(32'h4, 1'b0, 32'h0, "poll", d);
      n++;
    end
    dchk(d[1] ? 32'(cyc - s) : 32'd0, 268, 270, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 dchk({27'd0, awready, wready, bvalid, arready, rvalid}, 0, 0, "reset_handshake");
    rstn = 1'b0;
    rc(32'h4, 32'h0, "status_reset");
    rc(32'hC00, 32'h0, "out0_reset");
    rc(32'h1000, 32'h0, "hw00_reset");
    rc(32'h3FFC, 32'h0, "unmapped");

    for (int o = 0; o < 5; o++) wr(32'hA00 + 4 * o, 32'h100000);
    wr(32'h0, 32'h2);
    c0 = wr_cyc;
    rc(32'h4, 32'h1, "busy_after_start");
    wr(32'h100, 32'h123456);
    wr(32'h0, 32'h2);
    while (cyc < c0 + 255) @(posedge clk);
    rc(32'h4, 32'h1, "busy_late");
    wait_done("latency_bias", c0);
    for (int o = 0; o < 5; o++) rc(32'hC00 + 4 * o, 32'h00100000, $sformatf("out%0d_bias", o));
    rc(32'h0, 32'h0, "ctrl_reads_zero");
    rc(32'h100, 32'h0, "busy_write_dropped");

    for (int o = 0; o < 5; o++) wr(32'hA00 + 4 * o, 32'h0);
    wr(32'h1000, 32'h200000);
    wr(32'h100, 32'hE00000);
    wr(32'h2000, 32'h100000);
    wr(32'h0, 32'h2);
    c0 = wr_cyc;
    wait_done("latency_neg", c0);
    rc(32'h4, 32'h2, "done_status");
    rc(32'hC00, 32'h00F00000, "out0_neg_half");
    rc(32'hC04, 32'h0, "out1_zero");

    for (int k = 0; k < 200; k++) wr(32'h1000 + 4 * k, 32'h200000);
    for (int i = 0; i < 25; i++) wr(32'h100 + 4 * i, 32'h200000);
    for (int k = 0; k < 40; k++) wr(32'h2000 + 4 * k, k >= 32 ? 32'hE00000 : 32'h200000);
    wr(32'h0, 32'h2);
    c0 = wr_cyc;
    wait_done("latency_sat", c0);
    for (int o = 0; o < 5; o++)
      rc(32'hC00 + 4 * o, o == 4 ? 32'h00E00000 : 32'h00200000, $sformatf("out%0d_sat", o));

    wr(32'h0, 32'h1);
    rc(32'hC00, 32'h0, "out0_cleared");
    rc(32'h4, 32'h0, "status_cleared");

    wr(32'h0, 32'h2);
    repeat (100) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    rc(32'h4, 32'h0, "status_after_reset");
    rc(32'hC00, 32'h0, "out0_after_reset");
    rc(32'h1000, 32'h0, "hw00_after_reset");
    rc(32'h100, 32'h0, "in0_after_reset");
    wr(32'hA00, 32'h100000);
    wr(32'h0, 32'h2);
    c0 = wr_cyc;
    wait_done("latency_after_reset", c0);
    rc(32'hC00, 32'h00100000, "out0_rerun");

    repeat (3) @(posedge clk);
    dchk(32'(q.size()), 0, 0, "scoreboard_drained");
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
